store_buffer_rv: RTL and testbench

//  Posted-write store buffer between the RV core's data write port and the data-memory bus.

---
 rtl/store_buffer_rv.sv | 135 +++++++++++++
 tb/tb_store_buffer_rv.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/store_buffer_rv.sv
// store_buffer_rv
//   Posted-write store buffer between the RV core data write port and the
//   data-memory bus. Core stores are lane-aligned and queued in an in-order
//   FIFO. The FIFO drains to memory over a valid/ready bus. Core loads are
//   checked against the pending stores.
//
//   Build option: define STORE_BUFFER_FWD_EN to merge pending store bytes into
//   load data (forwarding). Without it, a hit raises owLoadHazard instead.
//
// Ports
//   iwClk, iwRst            clock, synchronous active-high reset
//   iwWriteAddr/Data/Wstrb  core store (right-justified data, strobe != 0 = request)
//   owStall                 store request refused because the FIFO is full
//   iwLoadAddr, iwMemLoadData, owLoadData, owLoadHazard   load check / forward path
//   owBusValid/Addr/Data/Wstrb, iwBusReady                memory write bus (head entry)
//   owFull, owEmpty         FIFO occupancy flags
module store_buffer_rv #(
  parameter int DEPTH = 4
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  output logic        owStall,
  input  logic [31:0] iwLoadAddr,
  input  logic [31:0] iwMemLoadData,
  output logic [31:0] owLoadData,
  output logic        owLoadHazard,
  output logic        owBusValid,
  output logic [31:0] owBusAddr,
  output logic [31:0] owBusData,
  output logic [3:0]  owBusWstrb,
  input  logic        iwBusReady,
  output logic        owFull,
  output logic        owEmpty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [3:0]       r_strb [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic [1:0]       w_sh;
  logic [3:0]       w_strb;
  logic [31:0]      w_data;
  logic             w_req;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_match;
  logic             w_unused;

  // Lane alignment; lanes shifted past bit 3 fall off (word-crossing store truncated).
  assign w_sh   = iwWriteAddr[1:0];
  assign w_strb = iwWstrb << w_sh;
  assign w_data = iwWriteData << {w_sh, 3'b000};

  assign w_req   = |iwWstrb;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Full is judged on the registered count: a same-cycle pop does not free a slot.
  assign w_push  = w_req && !w_full && (|w_strb);
  assign w_pop   = !w_empty && iwBusReady;

  assign owStall    = w_req && w_full;
  assign owFull     = w_full;
  assign owEmpty    = w_empty;
  assign owBusValid = !w_empty;
  assign owBusAddr  = {r_addr[r_rd_ptr], 2'b00};
  assign owBusData  = r_data[r_rd_ptr];
  assign owBusWstrb = r_strb[r_rd_ptr];

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr] <= iwWriteAddr[31:2];
        r_data[r_wr_ptr] <= w_data;
        r_strb[r_wr_ptr] <= w_strb;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      // Push and pop never target the same slot: push needs !full, pop needs !empty.
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Word-address match against every live entry; the store entering this
  // cycle is not yet in r_vld, so it is never checked.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++)
      w_match[i] = r_vld[i] && (r_addr[i] == iwLoadAddr[31:2]);
  end

  assign w_unused = ^iwLoadAddr[1:0];

`ifdef STORE_BUFFER_FWD_EN
  // Overlay from oldest (rd_ptr) to youngest so the youngest byte wins.
  always_comb begin
    owLoadData = iwMemLoadData;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[r_rd_ptr + PW'(k)]) begin
        for (int b = 0; b < 4; b++)
          if (r_strb[r_rd_ptr + PW'(k)][b])
            owLoadData[8*b +: 8] = r_data[r_rd_ptr + PW'(k)][8*b +: 8];
      end
    end
  end
  assign owLoadHazard = 1'b0;
`else
  assign owLoadData   = iwMemLoadData;
  assign owLoadHazard = |w_match;
`endif

endmodule

// File: tb/tb_store_buffer_rv.sv
module tb_store_buffer_rv;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] waddr, wdata, laddr, mdata;
  logic [3:0]  wstrb;
  logic        stall, hazard, bvalid, bready, full, empty;
  logic [31:0] ldata, baddr, bdata;
  logic [3:0]  bstrb;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer_rv #(.DEPTH(4)) dut (
    .iwClk(clk), .iwRst(rst),
    .iwWriteAddr(waddr), .iwWriteData(wdata), .iwWstrb(wstrb), .owStall(stall),
    .iwLoadAddr(laddr), .iwMemLoadData(mdata), .owLoadData(ldata), .owLoadHazard(hazard),
    .owBusValid(bvalid), .owBusAddr(baddr), .owBusData(bdata), .owBusWstrb(bstrb),
    .iwBusReady(bready), .owFull(full), .owEmpty(empty)
  );

  // Advance one edge; inputs are then changed and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr = a; wdata = d; wstrb = s;
    tick();
    wstrb = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bvalid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_byte_lane();
    bready = 1'b1;
    store(32'h1003, 32'hAB, 4'b0001);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL byte_valid got %b exp 1", bvalid); end
    checks++; if (baddr !== 32'h1000) begin errors++; $display("FAIL byte_addr got %h exp 00001000", baddr); end
    checks++; if (bstrb !== 4'b1000) begin errors++; $display("FAIL byte_strb got %b exp 1000", bstrb); end
    checks++; if (bdata !== 32'hAB000000) begin errors++; $display("FAIL byte_data got %h exp ab000000", bdata); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL byte_empty_after got %b exp 1", empty); end
  endtask

  task automatic test_truncate();
    bready = 1'b1;
    store(32'h302, 32'hAABBCCDD, 4'b1111);
    checks++; if (bstrb !== 4'b1100) begin errors++; $display("FAIL trunc_strb got %b exp 1100", bstrb); end
    checks++; if (bdata !== 32'hCCDD0000) begin errors++; $display("FAIL trunc_data got %h exp ccdd0000", bdata); end
    checks++; if (baddr !== 32'h300) begin errors++; $display("FAIL trunc_addr got %h exp 00000300", baddr); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL trunc_empty got %b exp 1", empty); end
  endtask

  task automatic test_full();
    logic [31:0] exp_a [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    bready = 1'b0;
    for (int i = 0; i < 4; i++) store(exp_a[i], 32'h100 + i, 4'b1111);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    waddr = 32'h10; wdata = 32'h55; wstrb = 4'b1111; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", stall); end
    tick();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_no_enq got %b exp 1", full); end
    bready = 1'b1; #1;
    // Same-cycle pop must not relieve the stall.
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall_with_pop got %b exp 1", stall); end
    checks++; if (baddr !== 32'h0) begin errors++; $display("FAIL full_head got %h exp 00000000", baddr); end
    tick();
    bready = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_stall_drop got %b exp 0", stall); end
    wstrb = 4'b0000;
    bready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++; if (baddr !== exp_a[i]) begin errors++; $display("FAIL full_order%0d got %h exp %h", i, baddr, exp_a[i]); end
      checks++; if (bdata !== 32'h100 + i) begin errors++; $display("FAIL full_data%0d got %h exp %h", i, bdata, 32'h100 + i); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    bready = 1'b0;
    store(32'h20, 32'hA0, 4'b1111);
    store(32'h24, 32'hA4, 4'b1111);
    bready = 1'b1;
    waddr = 32'h28; wdata = 32'hA8; wstrb = 4'b1111; #1;
    checks++; if (baddr !== 32'h20) begin errors++; $display("FAIL b2b_head got %h exp 00000020", baddr); end
    tick();
    wstrb = 4'b0000;
    checks++; if (baddr !== 32'h24) begin errors++; $display("FAIL b2b_second got %h exp 00000024", baddr); end
    tick();
    checks++; if (baddr !== 32'h28) begin errors++; $display("FAIL b2b_third got %h exp 00000028", baddr); end
    checks++; if (bdata !== 32'hA8) begin errors++; $display("FAIL b2b_third_data got %h exp 000000a8", bdata); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_count got empty=%b exp 1", empty); end
  endtask

  task automatic test_forward();
    bready = 1'b0;
    store(32'h200, 32'h11223344, 4'b1111);
    store(32'h201, 32'h55, 4'b0001);
    laddr = 32'h200; mdata = 32'h0; #1;
`ifdef STORE_BUFFER_FWD_EN
    checks++; if (ldata !== 32'h11225544) begin errors++; $display("FAIL fwd_data got %h exp 11225544", ldata); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL fwd_hazard got %b exp 0", hazard); end
`else
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_hit got %b exp 1", hazard); end
    checks++; if (ldata !== 32'h0) begin errors++; $display("FAIL haz_data got %h exp 00000000", ldata); end
`endif
    laddr = 32'h204; mdata = 32'hDEADBEEF; #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL load_miss_hazard got %b exp 0", hazard); end
    checks++; if (ldata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_miss_data got %h exp deadbeef", ldata); end
  endtask

  task automatic test_reset_mid_drain();
    store(32'h208, 32'h77, 4'b1111);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", bvalid); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", bvalid); end
    laddr = 32'h200; #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL mid_hazard got %b exp 0", hazard); end
    bready = 1'b1; tick();
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL mid_no_handshake got %b exp 0", bvalid); end
  endtask

  initial begin
    rst = 1'b0; waddr = '0; wdata = '0; wstrb = '0; laddr = '0; mdata = '0; bready = 1'b0;
    @(negedge clk);
    test_reset();
    test_byte_lane();
    test_truncate();
    test_full();
    test_back_to_back();
    test_forward();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
